// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, ACK/NACK bit levels, default address.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_SUB,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Target address shared with the master's testbench.
  localparam logic [6:0] DEFAULT_ADDR = 7'h4C;

  // Open-drain drive level needed to put a given bit value on SDA.
  function automatic logic pull(input logic bit_val);
    return ~bit_val;
  endfunction

endpackage

// File: rtl/i2c_pin_filter.sv
// Pin conditioner: 2-flop synchronizer, FILT-sample glitch filter, edge pulses.
module i2c_pin_filter #(
  parameter int unsigned FILT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = (FILT > 1) ? $clog2(FILT) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          prev;

  // Synchronize, then accept a new level only after FILT agreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= 2'b11;
      level <= 1'b1;
      prev  <= 1'b1;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], pin};
      prev <= level;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Edge pulses from previous and current filtered levels.
  always_comb begin
    rise = level & ~prev;
    fall = ~level & prev;
  end

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: address match, sub-address, register write/read with auto-increment.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  ADDR = DEFAULT_ADDR,
  parameter int unsigned FILT = 3
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;
  logic start, stop;

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic [7:0] rx_byte;
  logic       byte_end, byte_end_n;    // 8 bits seen, waiting for the falling edge
  logic       ack_phase, ack_phase_n;  // target is driving ACK (9th clock)
  logic       mack, mack_n;            // master ACK/NACK bit of a read byte
  logic       rd_load, rd_load_n;      // master ACKed; reload on next falling edge
  logic       sda_oe_n, reg_wr_n, reg_rd_n, busy_n;
  logic [7:0] reg_addr_n, reg_wdata_n;

  i2c_pin_filter #(.FILT(FILT)) u_scl (
    .clk   (clk_50),
    .rst   (rst),
    .pin   (scl_in),
    .level (scl_f),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_pin_filter #(.FILT(FILT)) u_sda (
    .clk   (clk_50),
    .rst   (rst),
    .pin   (sda_in),
    .level (sda_f),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  // Bus conditions: SDA moving while SCL is high.
  always_comb begin
    start = sda_fall & scl_f;
    stop  = sda_rise & scl_f;
  end

  // State and output registers.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      byte_end  <= 1'b0;
      ack_phase <= 1'b0;
      mack      <= 1'b0;
      rd_load   <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      byte_end  <= byte_end_n;
      ack_phase <= ack_phase_n;
      mack      <= mack_n;
      rd_load   <= rd_load_n;
      sda_oe    <= sda_oe_n;
      reg_addr  <= reg_addr_n;
      reg_wdata <= reg_wdata_n;
      reg_wr    <= reg_wr_n;
      reg_rd    <= reg_rd_n;
      busy      <= busy_n;
    end
  end

  // Next-state and output logic; START/STOP take priority over bit events.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    byte_end_n  = byte_end;
    ack_phase_n = ack_phase;
    mack_n      = mack;
    rd_load_n   = rd_load;
    sda_oe_n    = sda_oe;
    reg_addr_n  = reg_addr;
    reg_wdata_n = reg_wdata;
    reg_wr_n    = 1'b0;
    reg_rd_n    = 1'b0;
    busy_n      = busy;
    rx_byte     = {shift[6:0], sda_f};

    // Sub-address advances on the cycle after each write strobe.
    if (reg_wr) begin
      reg_addr_n = reg_addr + 8'd1;
    end

    if (start) begin
      state_n     = ST_ADDR;
      bit_cnt_n   = '0;
      byte_end_n  = 1'b0;
      ack_phase_n = 1'b0;
      mack_n      = 1'b0;
      rd_load_n   = 1'b0;
      sda_oe_n    = 1'b0;
      busy_n      = 1'b1;
    end else if (stop) begin
      state_n     = ST_IDLE;
      bit_cnt_n   = '0;
      byte_end_n  = 1'b0;
      ack_phase_n = 1'b0;
      mack_n      = 1'b0;
      rd_load_n   = 1'b0;
      sda_oe_n    = 1'b0;
      busy_n      = 1'b0;
    end else begin
      unique case (state)
        ST_ADDR, ST_SUB, ST_WDATA: begin
          if (scl_fall) begin
            if (byte_end) begin
              sda_oe_n    = pull(ACK);
              byte_end_n  = 1'b0;
              ack_phase_n = 1'b1;
            end else if (ack_phase) begin
              sda_oe_n    = 1'b0;
              ack_phase_n = 1'b0;
              bit_cnt_n   = '0;
              if (state == ST_ADDR) begin
                // Address byte is still in shift; bit 0 is R/W.
                if (shift[0]) begin
                  state_n  = ST_RDATA;
                  reg_rd_n = 1'b1;
                  shift_n  = reg_rdata;
                end else begin
                  state_n = ST_SUB;
                end
              end else if (state == ST_SUB) begin
                state_n = ST_WDATA;
              end
            end
          end else if (scl_rise && !byte_end && !ack_phase) begin
            shift_n   = rx_byte;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ST_ADDR) begin
                if (rx_byte[7:1] == ADDR) begin
                  byte_end_n = 1'b1;
                end else begin
                  state_n = ST_IGNORE;
                end
              end else if (state == ST_SUB) begin
                reg_addr_n = rx_byte;
                byte_end_n = 1'b1;
              end else begin
                reg_wdata_n = rx_byte;
                reg_wr_n    = 1'b1;
                byte_end_n  = 1'b1;
              end
            end
          end
        end

        ST_RDATA: begin
          // First bit of a freshly loaded byte goes out the cycle after the load.
          if (reg_rd) begin
            sda_oe_n = pull(shift[7]);
          end
          if (scl_rise) begin
            if (mack) begin
              mack_n = 1'b0;
              if (sda_f == ACK) begin
                rd_load_n  = 1'b1;
                reg_addr_n = reg_addr + 8'd1;
              end else begin
                state_n  = ST_IGNORE;
                sda_oe_n = 1'b0;
              end
            end else if (!byte_end && !rd_load) begin
              bit_cnt_n = bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_end_n = 1'b1;
              end else begin
                shift_n = {shift[6:0], 1'b0};
              end
            end
          end else if (scl_fall) begin
            if (byte_end) begin
              byte_end_n = 1'b0;
              mack_n     = 1'b1;
              sda_oe_n   = pull(NACK);
            end else if (rd_load) begin
              rd_load_n = 1'b0;
              reg_rd_n  = 1'b1;
              shift_n   = reg_rdata;
              bit_cnt_n = '0;
            end else if (!mack) begin
              sda_oe_n = pull(shift[7]);
            end
          end
        end

        ST_IGNORE: begin
          sda_oe_n = 1'b0;
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged I2C master with open-drain SDA.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int T = 30;  // quarter-ish bit phase in system clocks

  logic       clk;
  logic       rst;
  logic       m_scl, m_sda;
  logic       scl_in, sda_in;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr, reg_rd, busy;

  int passed = 0;
  int total  = 0;

  // Strobe log written only by the monitor.
  logic [7:0] wr_addr_log [64];
  logic [7:0] wr_data_log [64];
  logic [7:0] rd_addr_log [64];
  int wr_n = 0;
  int rd_n = 0;
  int oe_n = 0;

  i2c_target #(.ADDR(7'h4C), .FILT(3)) dut (
    .clk_50    (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  assign scl_in = m_scl;
  assign sda_in = m_sda & ~sda_oe;

  always_comb begin
    case (reg_addr)
      8'h10:   reg_rdata = 8'hA5;
      8'h11:   reg_rdata = 8'h3C;
      default: reg_rdata = 8'hEE;
    endcase
  end

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (reg_wr && wr_n < 64) begin
      wr_addr_log[wr_n] = reg_addr;
      wr_data_log[wr_n] = reg_wdata;
      wr_n = wr_n + 1;
    end
    if (reg_rd && rd_n < 64) begin
      rd_addr_log[rd_n] = reg_addr;
      rd_n = rd_n + 1;
    end
    if (sda_oe) oe_n = oe_n + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b0; wait_clk(T);
    m_scl = 1'b0; wait_clk(T);
  endtask

  task automatic bus_rstart();
    m_sda = 1'b1; wait_clk(T);
    m_scl = 1'b1; wait_clk(T);
    m_sda = 1'b0; wait_clk(T);
    m_scl = 1'b0; wait_clk(T);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_clk(T);
    m_scl = 1'b1; wait_clk(T);
    m_sda = 1'b1; wait_clk(T);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    wait_clk(T);
    m_scl = 1'b1; wait_clk(T);
    m_scl = 1'b0; wait_clk(T);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    m_sda = 1'b1; wait_clk(T);
    m_scl = 1'b1; wait_clk(T);
    ack = sda_in;
    m_scl = 1'b0; wait_clk(T);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    d = '0;
    for (int i = 0; i < 8; i++) begin
      m_sda = 1'b1; wait_clk(T);
      m_scl = 1'b1; wait_clk(T);
      d = {d[6:0], sda_in};
      m_scl = 1'b0; wait_clk(T);
    end
    m_sda = mack; wait_clk(T);
    m_scl = 1'b1; wait_clk(T);
    m_scl = 1'b0; wait_clk(T);
  endtask

  task automatic test_reset();
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    wait_clk(4);
    total++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); else passed++;
    total++; if (reg_addr !== 8'h00) $display("FAIL reset_reg_addr: got %h expected 00", reg_addr); else passed++;
    total++; if (reg_wdata !== 8'h00) $display("FAIL reset_reg_wdata: got %h expected 00", reg_wdata); else passed++;
    total++; if ({reg_wr, reg_rd} !== 2'b00) $display("FAIL reset_strobes: got %b expected 00", {reg_wr, reg_rd}); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    rst = 1'b0;
    wait_clk(20);
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int w0;
    w0 = wr_n;
    bus_start();
    total++; if (busy !== 1'b1) $display("FAIL write_busy_on: got %b expected 1", busy); else passed++;
    write_byte(8'h98, a0);
    write_byte(8'h01, a1);
    write_byte(8'h12, a2);
    total++; if ({a0, a1, a2} !== 3'b000) $display("FAIL write_acks: got %b expected 000", {a0, a1, a2}); else passed++;
    bus_stop();
    wait_clk(10);
    total++; if (busy !== 1'b0) $display("FAIL write_busy_off: got %b expected 0", busy); else passed++;
    total++; if (wr_n - w0 != 1) $display("FAIL write_count: got %0d expected 1", wr_n - w0); else passed++;
    total++; if ({wr_addr_log[w0], wr_data_log[w0]} !== 16'h0112) $display("FAIL write_entry: got %h expected 0112", {wr_addr_log[w0], wr_data_log[w0]}); else passed++;
    total++; if (reg_addr !== 8'h02) $display("FAIL write_addr_inc: got %h expected 02", reg_addr); else passed++;
  endtask

  task automatic test_burst_wrap();
    logic [15:0] exp [4];
    logic [7:0]  dat [4];
    logic        ack, acks;
    int w0;
    exp[0] = 16'hFE12; exp[1] = 16'hFF34; exp[2] = 16'h0056; exp[3] = 16'h0178;
    dat[0] = 8'h12; dat[1] = 8'h34; dat[2] = 8'h56; dat[3] = 8'h78;
    acks = 1'b0;
    w0 = wr_n;
    bus_start();
    write_byte(8'h98, ack); acks = acks | ack;
    write_byte(8'hFE, ack); acks = acks | ack;
    for (int i = 0; i < 4; i++) begin
      write_byte(dat[i], ack);
      acks = acks | ack;
    end
    bus_stop();
    wait_clk(10);
    total++; if (acks !== 1'b0) $display("FAIL burst_acks: got nack seen=%b expected 0", acks); else passed++;
    total++; if (wr_n - w0 != 4) $display("FAIL burst_count: got %0d expected 4", wr_n - w0); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({wr_addr_log[w0+i], wr_data_log[w0+i]} !== exp[i])
        $display("FAIL burst_entry%0d: got %h expected %h", i, {wr_addr_log[w0+i], wr_data_log[w0+i]}, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_mismatch();
    logic ack, ack2;
    int w0, r0, o0;
    w0 = wr_n; r0 = rd_n; o0 = oe_n;
    bus_start();
    write_byte(8'hA0, ack);
    total++; if (ack !== 1'b1) $display("FAIL mismatch_nack: got %b expected 1", ack); else passed++;
    total++; if (oe_n != o0) $display("FAIL mismatch_oe: got %0d driven cycles expected 0", oe_n - o0); else passed++;
    write_byte(8'h55, ack2);
    total++; if (busy !== 1'b1) $display("FAIL mismatch_busy: got %b expected 1", busy); else passed++;
    bus_stop();
    wait_clk(10);
    total++; if ((wr_n - w0) + (rd_n - r0) != 0) $display("FAIL mismatch_strobes: got %0d expected 0", (wr_n - w0) + (rd_n - r0)); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mismatch_busy_off: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_read();
    logic       a0, a1, a2;
    logic [7:0] d0, d1;
    int w0, r0;
    w0 = wr_n; r0 = rd_n;
    bus_start();
    write_byte(8'h98, a0);
    write_byte(8'h10, a1);
    bus_rstart();
    write_byte(8'h99, a2);
    total++; if ({a0, a1, a2} !== 3'b000) $display("FAIL read_acks: got %b expected 000", {a0, a1, a2}); else passed++;
    read_byte(ACK, d0);
    read_byte(NACK, d1);
    total++; if (d0 !== 8'hA5) $display("FAIL read_byte0: got %h expected a5", d0); else passed++;
    total++; if (d1 !== 8'h3C) $display("FAIL read_byte1: got %h expected 3c", d1); else passed++;
    total++; if (sda_oe !== 1'b0) $display("FAIL read_release: got %b expected 0", sda_oe); else passed++;
    bus_stop();
    wait_clk(10);
    total++; if (rd_n - r0 != 2) $display("FAIL read_count: got %0d expected 2", rd_n - r0); else passed++;
    total++; if ({rd_addr_log[r0], rd_addr_log[r0+1]} !== 16'h1011) $display("FAIL read_addrs: got %h expected 1011", {rd_addr_log[r0], rd_addr_log[r0+1]}); else passed++;
    total++; if (wr_n - w0 != 0) $display("FAIL read_no_wr: got %0d expected 0", wr_n - w0); else passed++;
  endtask

  task automatic test_partial_stop();
    logic a0, a1, a2, a3, a4;
    int w0;
    w0 = wr_n;
    bus_start();
    write_byte(8'h98, a0);
    write_byte(8'h20, a1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    bus_stop();
    wait_clk(10);
    total++; if (wr_n - w0 != 0) $display("FAIL partial_no_wr: got %0d expected 0", wr_n - w0); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL partial_idle: got %b expected 0", busy); else passed++;
    bus_start();
    write_byte(8'h98, a2);
    write_byte(8'h30, a3);
    write_byte(8'h77, a4);
    bus_stop();
    wait_clk(10);
    total++; if ({a0, a1, a2, a3, a4} !== 5'b0) $display("FAIL partial_acks: got %b expected 00000", {a0, a1, a2, a3, a4}); else passed++;
    total++; if (wr_n - w0 != 1) $display("FAIL partial_next_count: got %0d expected 1", wr_n - w0); else passed++;
    total++; if ({wr_addr_log[w0], wr_data_log[w0]} !== 16'h3077) $display("FAIL partial_next_entry: got %h expected 3077", {wr_addr_log[w0], wr_data_log[w0]}); else passed++;
  endtask

  task automatic test_reset_mid();
    logic a0, a1, a2;
    int w0;
    bus_start();
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b0); write_bit(1'b1);
    total++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b expected 1", busy); else passed++;
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    total++; if ({sda_oe, busy} !== 2'b00) $display("FAIL rstmid_outputs: got %b expected 00", {sda_oe, busy}); else passed++;
    total++; if (reg_addr !== 8'h00) $display("FAIL rstmid_reg_addr: got %h expected 00", reg_addr); else passed++;
    m_sda = 1'b1; wait_clk(T);
    m_scl = 1'b1; wait_clk(T);
    total++; if (busy !== 1'b0) $display("FAIL rstmid_ignored: got %b expected 0", busy); else passed++;
    w0 = wr_n;
    bus_start();
    write_byte(8'h98, a0);
    write_byte(8'h05, a1);
    write_byte(8'h66, a2);
    bus_stop();
    wait_clk(10);
    total++; if ({a0, a1, a2} !== 3'b000) $display("FAIL rstmid_acks: got %b expected 000", {a0, a1, a2}); else passed++;
    total++; if (wr_n - w0 != 1 || {wr_addr_log[w0], wr_data_log[w0]} !== 16'h0566)
      $display("FAIL rstmid_write: got count %0d entry %h expected 1 0566", wr_n - w0, {wr_addr_log[w0], wr_data_log[w0]});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_burst_wrap();
    test_mismatch();
    test_read();
    test_partial_stop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) endpoint: the receiving end of the bus driven by the `I2C` master block. It oversamples SCL/SDA on the 50 MHz system clock and decodes START, STOP and repeated START. It matches a fixed 7-bit address, ACKs, and accepts a sub-address byte. It then writes data bytes into, or reads them from, an external byte-wide register port, with sub-address auto-increment. It sits between the board I2C pins (open-drain SDA via an output-enable) and the local register bank.

## Interface
- `ADDR`, 7'b1001100: 7-bit target address.
- `FILT`, 3: number of consecutive identical synchronized samples required before a SCL/SDA level change is accepted (glitch filter).
- `clk_50`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset. One clock (`clk_50`); reset is synchronous and active-high.
- `scl_in`  in  1  raw SCL pin level (asynchronous).
- `sda_in`  in  1  raw SDA pin level (asynchronous).
- `sda_oe`  out  1  1 = pull SDA low; 0 = release. Reset 0.
- `reg_addr`  out  8  current sub-address. Reset 8'h00.
- `reg_wdata`  out  8  byte received from master. Reset 8'h00.
- `reg_wr`  out  1  one-cycle write strobe. Reset 0.
- `reg_rd`  out  1  one-cycle read strobe; `reg_rdata` is sampled on the same cycle. Reset 0.
- `reg_rdata`  in  8  register read data, valid combinationally for `reg_addr`.
- `busy`  out  1  high from an accepted START until STOP. Reset 0.

## Operation
- Input conditioning:
  - Each pin passes through a 2-flop synchronizer, then a FILT-sample filter, producing `scl_f`/`sda_f`.
  - Edges are detected from the previous and current filtered levels.
- Bus conditions:
  - START or repeated START: `sda_f` falls while `scl_f` is high.
  - STOP: `sda_f` rises while `scl_f` is high.
  - START and STOP override any state.
- Data bits:
  - Sampled on the `scl_f` rising edge, MSB first.
  - The target changes `sda_oe` only after an `scl_f` falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. Then:
    - addr[7:1]==ADDR and R/W=0 -> ACK -> SUB.
    - Match with R/W=1 -> ACK -> RDATA.
    - Mismatch -> IGNORE, with no ACK.
  - SUB: shift 8 bits; load `reg_addr`; ACK -> WDATA.
  - WDATA: shift 8 bits. On the 8th rising edge, set `reg_wdata` and pulse `reg_wr` for one cycle. ACK, increment `reg_addr`, stay in WDATA.
  - RDATA:
    - On the falling edge that ends the address ACK or the master ACK, pulse `reg_rd` and latch `reg_rdata` into the shift register.
    - Drive `sda_oe = ~bit` for 8 bits, then release for the master ACK bit.
    - Master ACK (SDA low): increment `reg_addr`, reload, continue.
    - Master NACK: -> IGNORE.
  - ACK handling: `sda_oe`=1 from the falling edge after bit 8 until the next falling edge (the 9th clock).
  - IGNORE: `sda_oe`=0; wait for START or STOP.
- Sub-address behaviour:
  - Increment is 8-bit and wraps 8'hFF -> 8'h00.
  - A repeated START keeps `reg_addr`, so write-sub-address then repeated-START-read works.
- STOP:
  - -> IDLE, `busy`=0, `sda_oe`=0.
  - A partial byte is discarded (no `reg_wr`).
- `rst` mid-transfer:
  - All outputs take their reset values and the state returns to IDLE.
  - The remainder of the bus transaction is ignored until the next START.

## Timing
- Pin-to-decision latency is 2 sync cycles + FILT cycles, i.e. 5 clocks at the defaults.
- Bus speed:
  - Supported SCL up to 400 kHz.
  - Minimum SCL high/low ≥ FILT+4 clocks.
- `sda_oe` updates 1 clock after the detected `scl_f` falling edge, well inside tHD;DAT.
- `reg_wr`:
  - Asserted 1 clock after the 8th `scl_f` rising edge of a data byte.
  - `reg_addr`/`reg_wdata` are stable during the strobe.
  - `reg_addr` increments on the following cycle.
- `reg_rd`:
  - Asserted 1 clock after the qualifying falling edge.
  - The shift register loads on the same clock.
  - The first bit drives on the next clock.
- Simultaneous events:
  - START and STOP are mutually exclusive (different SDA directions).
  - Any START/STOP on the same cycle as a bit event wins.
- Clock stretching is not performed; the block never holds SCL.

## Structure
- Shared package `i2c_pkg`:
  - State enum (IDLE, ADDR, SUB, WDATA, RDATA, IGNORE).
  - Constants ACK=1'b0 and NACK=1'b1.
  - Default target address 7'h4C, shared with the master's testbench.
- Sub-module `i2c_pin_filter`:
  - Synchronizer + FILT counter + rise/fall pulses.
  - Instantiated twice (SCL, SDA).
- Everything else (FSM, 3-bit bit counter, 8-bit shift register, ACK phase flag) lives in `i2c_target`.

## Test plan
- Write: START, 0x98 (addr 0x4C, W), sub 0x01, data 0x12, STOP -> ACK on all three bytes; one `reg_wr` with `reg_addr`=0x01 and `reg_wdata`=0x12; `busy` 1 then 0.
- Burst write: sub 0xFE, data 0x12 0x34 0x56 0x78 -> four `reg_wr` at addresses 0xFE, 0xFF, 0x00, 0x01 (wrap).
- Address mismatch: START, 0xA0 -> no ACK (`sda_oe` stays 0 through the 9th clock); no strobes until STOP.
- Read: write sub 0x10, repeated START, 0x99, master ACK then NACK, with `reg_rdata`=0xA5/0x3C -> SDA carries 0xA5 then 0x3C; two `reg_rd` at addresses 0x10 and 0x11; `sda_oe` released after the NACK.
- STOP after 4 bits of a data byte -> no `reg_wr`; IDLE; next transaction works normally.
- `rst` asserted mid-address byte -> `sda_oe`=0 and `busy`=0 the next cycle; the following START/0x98 is ACKed.
